// File: rtl/sc_lives_levels_counter_pkg.sv
// Shared game package: FSM state encodings and default game parameters.
package sc_lives_levels_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PLAY    = 2'd1,
      ST_HOLDOFF = 2'd2,
      ST_OVER    = 2'd3
   } game_state_t;

   localparam int DEF_INIT_LIVES     = 3;
   localparam int DEF_MAX_LIVES      = 7;
   localparam int DEF_MAX_LEVEL      = 5;
   localparam int DEF_HOLDOFF_CYCLES = 16;

   // Bit positions of the strobe vector fed to the edge detectors.
   localparam int EV_NEW  = 3;
   localparam int EV_DOWN = 2;
   localparam int EV_UP   = 1;
   localparam int EV_LVL  = 0;

endpackage

// File: rtl/sc_lives_levels_counter_if.sv
// Strobe inputs and counter/flag outputs of the lives/levels counter.
interface sc_lives_levels_counter_if;
   logic       SC_LIVES_LEVELS_COUNTER_newGame_InLow;
   logic       SC_LIVES_LEVELS_COUNTER_lifeDown_InLow;
   logic       SC_LIVES_LEVELS_COUNTER_lifeUp_InLow;
   logic       SC_LIVES_LEVELS_COUNTER_levelUp_InLow;
   logic [2:0] SC_LIVES_LEVELS_COUNTER_lives_Out;
   logic [2:0] SC_LIVES_LEVELS_COUNTER_level_Out;
   logic       SC_LIVES_LEVELS_COUNTER_COMPARATOR_LIVES;
   logic       SC_LIVES_LEVELS_COUNTER_COMPARATOR_LEVELS;
   logic       SC_LIVES_LEVELS_COUNTER_holdoff_Out;

   modport master (
      output SC_LIVES_LEVELS_COUNTER_newGame_InLow, SC_LIVES_LEVELS_COUNTER_lifeDown_InLow,
             SC_LIVES_LEVELS_COUNTER_lifeUp_InLow, SC_LIVES_LEVELS_COUNTER_levelUp_InLow,
      input  SC_LIVES_LEVELS_COUNTER_lives_Out, SC_LIVES_LEVELS_COUNTER_level_Out,
             SC_LIVES_LEVELS_COUNTER_COMPARATOR_LIVES, SC_LIVES_LEVELS_COUNTER_COMPARATOR_LEVELS,
             SC_LIVES_LEVELS_COUNTER_holdoff_Out
   );

   modport slave (
      input  SC_LIVES_LEVELS_COUNTER_newGame_InLow, SC_LIVES_LEVELS_COUNTER_lifeDown_InLow,
             SC_LIVES_LEVELS_COUNTER_lifeUp_InLow, SC_LIVES_LEVELS_COUNTER_levelUp_InLow,
      output SC_LIVES_LEVELS_COUNTER_lives_Out, SC_LIVES_LEVELS_COUNTER_level_Out,
             SC_LIVES_LEVELS_COUNTER_COMPARATOR_LIVES, SC_LIVES_LEVELS_COUNTER_COMPARATOR_LEVELS,
             SC_LIVES_LEVELS_COUNTER_holdoff_Out
   );
endinterface

// File: rtl/sc_falling_edge_detect.sv
// 1-bit falling-edge detector; reset leaves history at "low seen" so a held-low
// input yields no event until it has been observed high.
module sc_falling_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic fall
);
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= d;
   end

   assign fall = prev_q & ~d;
endmodule

// File: rtl/sc_lives_levels_counter.sv
// Lives/levels counter FSM: edge-detected active-low strobes drive a
// IDLE/PLAY/HOLDOFF/OVER machine holding the life count and level.
module sc_lives_levels_counter
   import sc_lives_levels_counter_pkg::*;
#(
   parameter int INIT_LIVES     = DEF_INIT_LIVES,
   parameter int MAX_LIVES      = DEF_MAX_LIVES,
   parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
   parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
   input logic                      SC_LIVES_LEVELS_COUNTER_CLOCK_50,
   input logic                      SC_LIVES_LEVELS_COUNTER_RESET_InHigh,
   sc_lives_levels_counter_if.slave bus
);
   localparam int          HOLD_W    = $clog2(HOLDOFF_CYCLES + 1);
   localparam [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam [2:0]        LIVES_INI = 3'(INIT_LIVES);
   localparam [2:0]        LIVES_MAX = 3'(MAX_LIVES);
   localparam [2:0]        LEVEL_MAX = 3'(MAX_LEVEL);

   logic clk, rst;
   assign clk = SC_LIVES_LEVELS_COUNTER_CLOCK_50;
   assign rst = SC_LIVES_LEVELS_COUNTER_RESET_InHigh;

   logic [3:0] strobe, ev;
   assign strobe = {bus.SC_LIVES_LEVELS_COUNTER_newGame_InLow,
                    bus.SC_LIVES_LEVELS_COUNTER_lifeDown_InLow,
                    bus.SC_LIVES_LEVELS_COUNTER_lifeUp_InLow,
                    bus.SC_LIVES_LEVELS_COUNTER_levelUp_InLow};

   sc_falling_edge_detect u_edge [3:0] (
      .clk  (clk),
      .rst  (rst),
      .d    (strobe),
      .fall (ev)
   );

   game_state_t       state_q, state_d;
   logic [2:0]        lives_q, lives_d, level_q, level_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         lives_q <= LIVES_INI;
         level_q <= 3'd1;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         level_q <= level_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      level_d = level_q;
      hold_d  = hold_q;
      if (ev[EV_NEW]) begin
         state_d = ST_PLAY;
         lives_d = LIVES_INI;
         level_d = 3'd1;
         hold_d  = '0;
      end else if (state_q == ST_PLAY || state_q == ST_HOLDOFF) begin
         // Lock-out timer runs regardless of which strobe acts this cycle.
         if (state_q == ST_HOLDOFF) begin
            if (hold_q == HOLD_LAST) begin
               state_d = ST_PLAY;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         // An ignored lifeDown in HOLDOFF does not consume the cycle's slot.
         if (ev[EV_DOWN] && state_q == ST_PLAY) begin
            lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
            state_d = (lives_q <= 3'd1) ? ST_OVER : ST_HOLDOFF;
            hold_d  = '0;
         end else if (ev[EV_UP]) begin
            if (lives_q < LIVES_MAX) lives_d = lives_q + 3'd1;
         end else if (ev[EV_LVL]) begin
            if (level_q < LEVEL_MAX) level_d = level_q + 3'd1;
            if (level_q >= LEVEL_MAX - 3'd1) begin
               state_d = ST_OVER;
               hold_d  = '0;
            end
         end
      end
   end

   assign bus.SC_LIVES_LEVELS_COUNTER_lives_Out         = lives_q;
   assign bus.SC_LIVES_LEVELS_COUNTER_level_Out         = level_q;
   assign bus.SC_LIVES_LEVELS_COUNTER_COMPARATOR_LIVES  = (lives_q != 3'd0);
   assign bus.SC_LIVES_LEVELS_COUNTER_COMPARATOR_LEVELS = (level_q == LEVEL_MAX);
   assign bus.SC_LIVES_LEVELS_COUNTER_holdoff_Out       = (state_q == ST_HOLDOFF);
endmodule

// File: tb/tb_sc_lives_levels_counter.sv
// Self-checking bench: vector table, directed corner sequences, and a random
// phase checked cycle-by-cycle against a rule-level game model.
module tb_sc_lives_levels_counter;
   localparam int INIT = 3, MAXL = 7, MAXV = 5, HOLD = 16;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   sc_lives_levels_counter_if bus ();
   sc_lives_levels_counter #(
      .INIT_LIVES(INIT), .MAX_LIVES(MAXL), .MAX_LEVEL(MAXV), .HOLDOFF_CYCLES(HOLD)
   ) dut (
      .SC_LIVES_LEVELS_COUNTER_CLOCK_50     (clk),
      .SC_LIVES_LEVELS_COUNTER_RESET_InHigh (rst),
      .bus                                  (bus.slave)
   );

   int passed = 0, total = 0;
   bit model_chk = 0;

   // Model: plain integers derived from the game rules.
   int  m_lives, m_level, m_hold_left;
   bit  m_active, m_over;
   bit  p_n, p_d, p_u, p_l;

   function automatic logic [8:0] dut_out();
      return {bus.SC_LIVES_LEVELS_COUNTER_lives_Out, bus.SC_LIVES_LEVELS_COUNTER_level_Out,
              bus.SC_LIVES_LEVELS_COUNTER_COMPARATOR_LIVES,
              bus.SC_LIVES_LEVELS_COUNTER_COMPARATOR_LEVELS,
              bus.SC_LIVES_LEVELS_COUNTER_holdoff_Out};
   endfunction

   function automatic logic [8:0] pack(int lv, int lvl, bit cl, bit cv, bit ho);
      return {3'(lv), 3'(lvl), cl, cv, ho};
   endfunction

   task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got lives=%0d level=%0d cl=%b cv=%b ho=%b, want lives=%0d level=%0d cl=%b cv=%b ho=%b",
                    name, act[8:6], act[5:3], act[2], act[1], act[0], exp[8:6], exp[5:3], exp[2], exp[1], exp[0]);
   endtask

   task automatic chk_int(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   task automatic model_step(bit r, bit n, bit d, bit u, bit l);
      bit en, ed, eu, el, was_hold;
      if (r) begin
         m_lives = INIT; m_level = 1; m_hold_left = 0; m_active = 0; m_over = 0;
         p_n = 0; p_d = 0; p_u = 0; p_l = 0;
         return;
      end
      en = p_n && !n; ed = p_d && !d; eu = p_u && !u; el = p_l && !l;
      p_n = n; p_d = d; p_u = u; p_l = l;
      if (en) begin
         m_lives = INIT; m_level = 1; m_hold_left = 0; m_active = 1; m_over = 0;
      end else if (m_active && !m_over) begin
         was_hold = (m_hold_left > 0);
         if (was_hold) m_hold_left--;
         if (ed && !was_hold) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            if (m_lives == 0) begin m_over = 1; m_hold_left = 0; end
            else m_hold_left = HOLD;
         end else if (eu) begin
            m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
         end else if (el) begin
            m_level = (m_level + 1 > MAXV) ? MAXV : m_level + 1;
            if (m_level == MAXV) begin m_over = 1; m_hold_left = 0; end
         end
      end
   endtask

   function automatic logic [8:0] model_out();
      return pack(m_lives, m_level, m_lives != 0, m_level == MAXV, m_hold_left > 0);
   endfunction

   // One clock: drive, advance past the edge, update model, optionally compare.
   task automatic cyc(bit r, bit n, bit d, bit u, bit l);
      rst = r;
      bus.SC_LIVES_LEVELS_COUNTER_newGame_InLow  = n;
      bus.SC_LIVES_LEVELS_COUNTER_lifeDown_InLow = d;
      bus.SC_LIVES_LEVELS_COUNTER_lifeUp_InLow   = u;
      bus.SC_LIVES_LEVELS_COUNTER_levelUp_InLow  = l;
      @(posedge clk); #1;
      model_step(r, n, d, u, l);
      if (model_chk) chk("model", dut_out(), model_out());
   endtask

   task automatic idle(int k);
      for (int i = 0; i < k; i++) cyc(0, 1, 1, 1, 1);
   endtask

   task automatic new_game();
      cyc(0, 1, 1, 1, 1); cyc(0, 0, 1, 1, 1); cyc(0, 1, 1, 1, 1);
   endtask

   typedef struct {
      bit n, d, u, l;
      int lives, level;
      bit cl, cv, ho;
   } vec_t;
   vec_t tbl[16];

   function automatic vec_t mk(bit n, bit d, bit u, bit l, int lv, int lvl, bit cl, bit cv, bit ho);
      vec_t v;
      v.n = n; v.d = d; v.u = u; v.l = l;
      v.lives = lv; v.level = lvl; v.cl = cl; v.cv = cv; v.ho = ho;
      return v;
   endfunction

   initial begin
      int ho_cnt;
      bit sn, sd, su, sl, sr;

      tbl[0]  = mk(1,1,1,1, 3,1, 1,0,0);
      tbl[1]  = mk(0,1,1,1, 3,1, 1,0,0);
      tbl[2]  = mk(1,1,1,1, 3,1, 1,0,0);
      tbl[3]  = mk(1,1,1,0, 3,2, 1,0,0);
      tbl[4]  = mk(1,1,1,0, 3,2, 1,0,0);
      tbl[5]  = mk(1,1,1,1, 3,2, 1,0,0);
      tbl[6]  = mk(1,1,1,0, 3,3, 1,0,0);
      tbl[7]  = mk(1,1,1,1, 3,3, 1,0,0);
      tbl[8]  = mk(1,1,1,0, 3,4, 1,0,0);
      tbl[9]  = mk(1,1,1,1, 3,4, 1,0,0);
      tbl[10] = mk(1,1,1,0, 3,5, 1,1,0);
      tbl[11] = mk(1,1,1,1, 3,5, 1,1,0);
      tbl[12] = mk(1,1,1,0, 3,5, 1,1,0);
      tbl[13] = mk(1,1,1,1, 3,5, 1,1,0);
      tbl[14] = mk(1,1,0,1, 3,5, 1,1,0);
      tbl[15] = mk(1,1,1,1, 3,5, 1,1,0);

      cyc(1, 1, 1, 1, 1); cyc(1, 1, 1, 1, 1);
      chk("reset_state", dut_out(), pack(3, 1, 1, 0, 0));

      // Start game, level up to the win, then confirm OVER freezes counters.
      for (int i = 0; i < 16; i++) begin
         cyc(0, tbl[i].n, tbl[i].d, tbl[i].u, tbl[i].l);
         chk($sformatf("vec%0d", i), dut_out(),
             pack(tbl[i].lives, tbl[i].level, tbl[i].cl, tbl[i].cv, tbl[i].ho));
      end

      // lifeDown held low 40 cycles: one decrement, 16 cycles of holdoff.
      new_game();
      ho_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(0, 1, 0, 1, 1);
         if (bus.SC_LIVES_LEVELS_COUNTER_holdoff_Out) ho_cnt++;
         if (i == 0) chk("down_first_edge", dut_out(), pack(2, 1, 1, 0, 1));
      end
      chk_int("holdoff_len", ho_cnt, 16);
      chk("down_held_end", dut_out(), pack(2, 1, 1, 0, 0));

      // Second lifeDown inside holdoff is ignored.
      new_game();
      cyc(0, 1, 0, 1, 1); cyc(0, 1, 1, 1, 1); idle(2);
      cyc(0, 1, 0, 1, 1); cyc(0, 1, 1, 1, 1);
      chk("down_in_holdoff", dut_out(), pack(2, 1, 1, 0, 1));

      // Three spaced lifeDowns reach OVER with no lives; newGame recovers.
      new_game();
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 0, 1, 1); cyc(0, 1, 1, 1, 1); idle(18);
      end
      chk("lives_zero_over", dut_out(), pack(0, 1, 0, 0, 0));
      new_game();
      chk("new_after_over", dut_out(), pack(3, 1, 1, 0, 0));
      cyc(0, 1, 1, 1, 0); cyc(0, 1, 1, 1, 1);
      chk("play_after_over", dut_out(), pack(3, 2, 1, 0, 0));

      // lifeUp saturation, then simultaneous lifeDown+lifeUp.
      new_game();
      for (int k = 0; k < 5; k++) begin cyc(0, 1, 1, 0, 1); cyc(0, 1, 1, 1, 1); end
      chk("lives_saturate", dut_out(), pack(7, 1, 1, 0, 0));
      cyc(0, 1, 0, 0, 1);
      chk("down_beats_up", dut_out(), pack(6, 1, 1, 0, 1));
      cyc(0, 1, 1, 1, 1);

      // Reset mid-holdoff with lifeDown still held low.
      new_game();
      cyc(0, 1, 0, 1, 1); idle(0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 1);
      cyc(1, 1, 0, 1, 1);
      chk("reset_mid_holdoff", dut_out(), pack(3, 1, 1, 0, 0));
      cyc(0, 1, 0, 1, 1); cyc(0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 1);
      chk("held_low_no_event", dut_out(), pack(3, 1, 1, 0, 0));
      cyc(0, 1, 1, 1, 1); cyc(0, 1, 0, 1, 1);
      chk("event_after_release", dut_out(), pack(2, 1, 1, 0, 1));

      // Random phase against the model.
      cyc(1, 1, 1, 1, 1);
      model_chk = 1;
      sn = 1; sd = 1; su = 1; sl = 1;
      for (int i = 0; i < 3000; i++) begin
         sr = ($urandom_range(0, 399) == 0);
         if (sn) sn = ($urandom_range(0, 59) != 0); else sn = ($urandom_range(0, 1) == 0);
         if (sd) sd = ($urandom_range(0, 7) != 0);  else sd = ($urandom_range(0, 1) == 0);
         if (su) su = ($urandom_range(0, 5) != 0);  else su = ($urandom_range(0, 1) == 0);
         if (sl) sl = ($urandom_range(0, 9) != 0);  else sl = ($urandom_range(0, 1) == 0);
         cyc(sr, sn, sd, su, sl);
      end
      model_chk = 0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
